// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requesting unit and serial_add_ctrl.
// The requester drives start/op/operands; the controller returns status and result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One 1-bit full adder is stepped LSB-first
// over WIDTH cycles, with the carry held in a flop between bits. Subtraction is
// done as a + ~b + 1. The result and carry registers double as the outputs and
// hold their value in IDLE until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout
// RUN   | one result bit per cycle, WIDTH cycles total
// DONE  | one-cycle done pulse, result valid
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_sum;
    logic fa_carry;

    FULL_ADDER u_fa (
        .in1   (a_sh_q[0]),
        .in2   (b_sh_q[0]),
        .c0    (carry_q),
        .Sum   (fa_sum),
        .Carry (fa_carry)
    );

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.op ? ~bus.b : bus.b;
                    carry_d  = bus.op ? 1'b1 : bus.cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decodes straight from state; result comes from the shift/carry flops.
    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
        bus.sum  = sum_sh_q;
        bus.cout = carry_q;
    end
endmodule

// Verified 1-bit full adder cell reused by the serial controller.
module FULL_ADDER (
    input  logic in1,
    input  logic in2,
    input  logic c0,
    output logic Sum,
    output logic Carry
);
    // Plain combinational sum and carry.
    always_comb begin
        Sum   = in1 ^ in2 ^ c0;
        Carry = (in1 & in2) | (c0 & (in1 ^ in2));
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 instance for directed and
// random traffic, a WIDTH=4 instance for the exhaustive sweep.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8 = 1'b1;
    logic rst4 = 1'b1;

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(4)) if4 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
    serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc_edge;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int free8 = 0;
    int free4 = 0;

    // Arithmetic reference: what the result of a w-bit add/sub must be.
    function automatic void ref_model(input int w, input logic op, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin,
                                      output logic [7:0] s, output logic c);
        longint m;
        longint r;
        m = longint'(1) << w;
        if (!op) begin
            r = longint'(a) + longint'(b) + longint'(cin);
            s = 8'(r % m);
            c = (r >= m);
        end else begin
            r = (longint'(a) - longint'(b) + m) % m;
            s = 8'(r);
            c = (a >= b);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus for the 8-bit DUT; the model decides whether this
    // edge accepts a start and, if so, queues the expected result.
    task automatic step8(input logic s, input logic op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic r,
                         output bit acc);
        int n;
        exp_t e;
        if8.start = s; if8.op = op; if8.a = a; if8.b = b; if8.cin = cin; rst8 = r;
        n = cyc + 1;
        acc = 1'b0;
        if (r) begin
            q8.delete();
            free8 = n + 1;
        end else if (s && n >= free8) begin
            ref_model(8, op, a, b, cin, e.sum, e.cout);
            e.acc_edge = n;
            q8.push_back(e);
            free8 = n + 8 + 2;
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step4(input logic s, input logic op, input logic [3:0] a,
                         input logic [3:0] b, input logic cin, input logic r,
                         output bit acc);
        int n;
        exp_t e;
        if4.start = s; if4.op = op; if4.a = a; if4.b = b; if4.cin = cin; rst4 = r;
        n = cyc + 1;
        acc = 1'b0;
        if (r) begin
            q4.delete();
            free4 = n + 1;
        end else if (s && n >= free4) begin
            ref_model(4, op, {4'h0, a}, {4'h0, b}, cin, e.sum, e.cout);
            e.acc_edge = n;
            q4.push_back(e);
            free4 = n + 4 + 2;
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle8(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    endtask

    task automatic op8(input logic op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bit acc;
        acc = 1'b0;
        while (!acc) step8(1'b1, op, a, b, cin, 1'b0, acc);
        idle8(10);
    endtask

    // Monitors: pop and compare whenever a DUT reports done.
    always @(negedge clk) begin
        exp_t e;
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = q8.pop_front();
                check("sum8", 32'(if8.sum), 32'(e.sum));
                check("cout8", 32'(if8.cout), 32'(e.cout));
                check("latency8", 32'(cyc - e.acc_edge), 32'd8);
                check("busy_in_done8", 32'(if8.busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if4.done === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL done4_unexpected: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = q4.pop_front();
                check("sum4", 32'(if4.sum), 32'(e.sum));
                check("cout4", 32'(if4.cout), 32'(e.cout));
                check("latency4", 32'(cyc - e.acc_edge), 32'd4);
            end
        end
    end

    initial begin
        bit acc;
        int busy_cnt;
        int wait_cnt;
        logic [7:0] ra;
        logic [7:0] rb;

        if4.start = 1'b0; if4.op = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        @(negedge clk);
        step8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        step8(1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 1'b1, acc);
        rst4 = 1'b0;
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_sum", 32'(if8.sum), 32'd0);
        check("rst_cout", 32'(if8.cout), 32'd0);

        // Zero add, with busy width measured directly.
        step8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        busy_cnt = (if8.busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
            if (if8.busy === 1'b1) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd8);

        op8(1'b0, 8'hFF, 8'h01, 1'b0);
        op8(1'b0, 8'hA5, 8'h5A, 1'b1);
        op8(1'b1, 8'h10, 8'h01, 1'b0);
        op8(1'b1, 8'h01, 8'h02, 1'b0);
        op8(1'b1, 8'h10, 8'h01, 1'b1);

        // start held for 12 cycles, operands switched to FF from the 4th cycle.
        for (int i = 0; i < 12; i++) begin
            if (i >= 3) step8(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, acc);
            else        step8(1'b1, 1'b0, 8'h03, 8'h04, 1'b0, 1'b0, acc);
        end
        idle8(12);

        // Reset on the 4th RUN cycle: the op is dropped and no done may follow.
        step8(1'b1, 1'b0, 8'h03, 8'h04, 1'b0, 1'b0, acc);
        idle8(3);
        step8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        check("midrst_busy", 32'(if8.busy), 32'd0);
        check("midrst_done", 32'(if8.done), 32'd0);
        check("midrst_sum", 32'(if8.sum), 32'd0);
        check("midrst_cout", 32'(if8.cout), 32'd0);
        idle8(14);
        op8(1'b0, 8'h7F, 8'h01, 1'b0);

        // Random traffic: operands churn every cycle, start toggles randomly.
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            step8(1'($urandom_range(0, 1)), 1'($urandom), ra, rb, 1'($urandom), 1'b0, acc);
        end
        idle8(12);

        // Exhaustive 4-bit sweep.
        for (int op = 0; op < 2; op++)
            for (int ci = 0; ci < 2; ci++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        acc = 1'b0;
                        while (!acc) step4(1'b1, 1'(op), 4'(a), 4'(b), 1'(ci), 1'b0, acc);
                    end
        for (int i = 0; i < 8; i++) step4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, acc);

        wait_cnt = 0;
        while ((q8.size() != 0 || q4.size() != 0) && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("drain_pending", 32'(q8.size() + q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller built around one FULL_ADDER cell. It sequences the adder LSB-first over WIDTH clock cycles through a carry flip-flop, giving N-bit arithmetic from a 1-bit datapath. The block sits between a requesting unit (start/done handshake) and the single FULL_ADDER instance it owns. It lets the team reuse the verified 1-bit cell instead of building a wide adder.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); bit counter is clog2(WIDTH) bits wide.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
start  input  1  request; sampled only in IDLE
op  input  1  0 = add (a+b+cin), 1 = subtract (a-b)
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in for add; ignored when op=1
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE state
sum  output  WIDTH  result; valid from done, held until next accepted start
cout  output  1  add: carry-out; subtract: 1 = no borrow (a>=b)

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst, rst sampled on the rising edge.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 at edge k:
  - load a_sh<=a;
  - load b_sh<=b when op=0, ~b when op=1;
  - carry<=cin when op=0, 1 when op=1;
  - clear sum_sh and cnt<=0, then go to RUN.
- IDLE with start=0: hold; sum/cout keep last result.
- RUN, each cycle: FULL_ADDER in1=a_sh[0], in2=b_sh[0], c0=carry. At the edge:
  - sum_sh <= {Sum, sum_sh[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1;
  - carry <= Carry;
  - cnt <= cnt+1.
- RUN exits to DONE on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH RUN cycles.
- DONE: done=1 and busy=0 for one cycle. sum=sum_sh and cout=carry, both valid and stable. Next state is always IDLE.
- Latency: start accepted at edge k, busy high cycles k+1..k+WIDTH, done high at cycle k+WIDTH+1. For WIDTH=8 that is 8 busy cycles and done at cycle 9. New start is accepted earliest at cycle k+WIDTH+2.
- start while in RUN or DONE is ignored, not queued. a, b, op and cin may change freely after acceptance.
- Width rules:
  - sum is modulo 2^WIDTH.
  - Add: cout is bit WIDTH of a+b+cin.
  - Subtract: sum = (a-b) mod 2^WIDTH, cout = (a>=b unsigned).
- Reset on any edge, including mid-RUN, puts the block in IDLE with busy=0, done=0, sum=0, cout=0. Shift registers, carry and cnt are cleared, and the partial operation is discarded.
- rst and start high on the same edge: rst wins.
- Exactly one FULL_ADDER instance; no other adder logic.

Test Plan:
- Reset then add: a=8'h00, b=8'h00, cin=0, op=0, start 1 cycle -> busy high 8 cycles, done at cycle 9, sum=8'h00, cout=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0, op=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- Subtract, two cases:
  - op=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - op=1, a=8'h01, b=8'h02, cin=0 -> sum=8'hFF, cout=0.
  - Repeat the first case with cin=1 -> identical result (cin ignored).
- Busy protection: start held high for 12 cycles with a=8'h03, b=8'h04 and operands changed to 8'hFF at cycle 3 -> exactly one done, at cycle 9, sum=8'h07, cout=0. A second operation is accepted at cycle 10.
- Reset mid-operation: rst pulsed at the 4th RUN cycle -> next cycle busy=0, done=0, sum=8'h00, cout=0, and no done pulse follows. A fresh start with a=8'h7F, b=8'h01 -> sum=8'h80, cout=0.
- Exhaustive regression, WIDTH=4: all a, b, cin, op combinations (1024) -> sum and cout match the reference model, done exactly WIDTH+1 cycles after each start.
